sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_pkg.sv | 8 +
 rtl/sa_beat_mux.sv | 17 +
 rtl/sa_ctrl.sv | 108 ++++++++++
 tb/tb_sa_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared constants and state encoding for the 3x3 systolic-array controller.
package sa_pkg;
    localparam int N                = 3;
    localparam int DATA_W_DEF       = 8;
    localparam int DRAIN_CYCLES_DEF = 6;
    localparam int C_W              = N * N * 2 * DATA_W_DEF;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
endpackage

// File: rtl/sa_beat_mux.sv
// sa_beat_mux: selects column k of A and row k of B for one feed beat.
module sa_beat_mux
    import sa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [N*N*DATA_W-1:0] a,
    input  logic [N*N*DATA_W-1:0] b,
    input  logic [1:0]            k,
    output logic [N*DATA_W-1:0]   a_col,
    output logic [N*DATA_W-1:0]   b_row
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign a_col[i*DATA_W +: DATA_W] = a[(N*i + int'(k))*DATA_W +: DATA_W];
        assign b_row[i*DATA_W +: DATA_W] = b[(N*int'(k) + i)*DATA_W +: DATA_W];
    end
endmodule

// File: rtl/sa_ctrl.sv
// sa_ctrl: job controller feeding a 3x3 systolic array and capturing its result.
// Optional SA_CTRL_JOB_CNT_EN adds a 16-bit completed-job counter output.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*DATA_W-1:0] a_mat,
    input  logic [N*N*DATA_W-1:0] b_mat,
    output logic [N*DATA_W-1:0]   arr_a,
    output logic [N*DATA_W-1:0]   arr_b,
    output logic                  arr_clr,
    input  logic [C_W-1:0]        arr_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [C_W-1:0]        c_out
`ifdef SA_CTRL_JOB_CNT_EN
    ,
    output logic [15:0]           job_cnt
`endif
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t                state;
    logic [1:0]            beat;
    logic [DW-1:0]         drain;
    logic [N*N*DATA_W-1:0] a_reg, b_reg, a_src, b_src;
    logic [N*DATA_W-1:0]   a_col, b_row;
    logic [1:0]            k;

    // The first beat is registered on the accepting edge, straight from the ports.
    assign a_src = (state == IDLE) ? a_mat : a_reg;
    assign b_src = (state == IDLE) ? b_mat : b_reg;
    assign k     = (state == FEED && beat != 2'd2) ? beat + 2'd1 : 2'd0;

    sa_beat_mux #(.DATA_W(DATA_W)) u_mux (
        .a     (a_src),
        .b     (b_src),
        .k     (k),
        .a_col (a_col),
        .b_row (b_row)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= '0;
            drain     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            in_ready  <= 1'b1;
            arr_clr   <= 1'b1;
            arr_a     <= '0;
            arr_b     <= '0;
            out_valid <= 1'b0;
            c_out     <= '0;
`ifdef SA_CTRL_JOB_CNT_EN
            job_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_reg    <= a_mat;
                    b_reg    <= b_mat;
                    beat     <= '0;
                    in_ready <= 1'b0;
                    arr_clr  <= 1'b0;
                    arr_a    <= a_col;
                    arr_b    <= b_row;
                    state    <= FEED;
                end
                FEED: if (beat == 2'd2) begin
                    arr_a <= '0;
                    arr_b <= '0;
                    drain <= '0;
                    state <= DRAIN;
                end else begin
                    beat  <= beat + 2'd1;
                    arr_a <= a_col;
                    arr_b <= b_row;
                end
                DRAIN: if (drain == DW'(DRAIN_CYCLES - 1)) begin
                    c_out     <= arr_c;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    drain <= drain + 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    arr_clr   <= 1'b1;
                    beat      <= '0;
                    drain     <= '0;
                    state     <= IDLE;
`ifdef SA_CTRL_JOB_CNT_EN
                    job_cnt   <= job_cnt + 16'd1;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: directed bench for sa_ctrl with a behavioural 3x3 accumulating array.
module tb_sa_ctrl;
    logic         clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, arr_clr, out_valid;
    logic [71:0]  a_mat = '0, b_mat = '0;
    logic [23:0]  arr_a, arr_b;
    logic [143:0] arr_c, c_out;
`ifdef SA_CTRL_JOB_CNT_EN
    logic [15:0]  job_cnt;
`endif
    logic [15:0]  acc [3][3];
    int           checks = 0, errors = 0;

    localparam logic [71:0]  ID    = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    localparam logic [71:0]  TWO_I = {8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2};
    localparam logic [71:0]  SEQ   = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [71:0]  ONES  = {9{8'd1}};
    localparam logic [71:0]  FULL  = {9{8'd255}};
    localparam logic [143:0] C_SEQ  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    localparam logic [143:0] C_2SEQ = {16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16, 16'd18};
    localparam logic [143:0] C_3    = {9{16'd3}};
    // 3*255*255 = 195075, minus 2*65536 leaves 64003
    localparam logic [143:0] C_FULL = {9{16'hFA03}};

    always #5 clk = ~clk;

    sa_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .arr_a     (arr_a),
        .arr_b     (arr_b),
        .arr_clr   (arr_clr),
        .arr_c     (arr_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out)
`ifdef SA_CTRL_JOB_CNT_EN
        ,
        .job_cnt   (job_cnt)
`endif
    );

    // Array stand-in: accumulates each beat's outer product, cleared by arr_clr.
    always_ff @(posedge clk)
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc[i][j] <= arr_clr ? 16'd0 : acc[i][j] + 16'(arr_a[i*8 +: 8]) * 16'(arr_b[j*8 +: 8]);

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                arr_c[(8 - (3*i + j))*16 +: 16] = acc[i][j];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1, the cycle opened by the accepting edge.
    task automatic start_job(input logic [71:0] a, input logic [71:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_ready: got %b want 1", in_ready);
        end
        a_mat    = a;
        b_mat    = b;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    // out_valid must first be seen in cycle 10 (3 feed + 6 drain + capture).
    task automatic wait_result(input int cyc0, input logic [143:0] exp, input string name);
        int cyc = cyc0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL %s_latency: got cycle %0d want 10", name, cyc);
        end
        checks++;
        if (c_out !== exp) begin
            errors++;
            $display("FAIL %s_c_out: got %h want %h", name, c_out, exp);
        end
    endtask

    task automatic take_result(input string name);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release_valid: got %b want 0", name, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release_ready: got %b want 1", name, in_ready);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick;
        checks += 5;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (arr_clr !== 1'b1) begin errors++; $display("FAIL rst_arr_clr: got %b want 1", arr_clr); end
        if ({arr_a, arr_b} !== 48'd0) begin errors++; $display("FAIL rst_arr: got %h want 0", {arr_a, arr_b}); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (c_out !== 144'd0) begin errors++; $display("FAIL rst_c_out: got %h want 0", c_out); end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick;
    endtask

    task automatic test_identity;
        start_job(ID, SEQ);
        checks += 3;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL feed_in_ready: got %b want 0", in_ready); end
        if (arr_clr !== 1'b0) begin errors++; $display("FAIL feed_arr_clr: got %b want 0", arr_clr); end
        if ({arr_a, arr_b} !== {24'h000001, 24'h030201}) begin errors++; $display("FAIL beat0: got %h want 000001030201", {arr_a, arr_b}); end
        tick;
        checks++;
        if ({arr_a, arr_b} !== {24'h000100, 24'h060504}) begin errors++; $display("FAIL beat1: got %h want 000100060504", {arr_a, arr_b}); end
        tick;
        checks++;
        if ({arr_a, arr_b} !== {24'h010000, 24'h090807}) begin errors++; $display("FAIL beat2: got %h want 010000090807", {arr_a, arr_b}); end
        tick;
        checks++;
        if ({arr_a, arr_b, arr_clr} !== 49'd0) begin errors++; $display("FAIL drain_arr: got %h want 0", {arr_a, arr_b, arr_clr}); end
        wait_result(4, C_SEQ, "identity");
        take_result("identity");
    endtask

    task automatic test_wrap;
        start_job(FULL, FULL);
        wait_result(1, C_FULL, "wrap");
        take_result("wrap");
    endtask

    task automatic test_back_to_back;
        start_job(ONES, ONES);
        wait_result(1, C_3, "b2b_first");
        in_valid = 1'b1;
        a_mat    = FULL;
        for (int n = 0; n < 5; n++) begin
            tick;
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%0d: got %b want 1", n, out_valid); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready_%0d: got %b want 0", n, in_ready); end
            if (c_out !== C_3) begin errors++; $display("FAIL hold_c_out_%0d: got %h want %h", n, c_out, C_3); end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_early_accept: got %b want 1", in_ready); end
        start_job(TWO_I, SEQ);
        wait_result(1, C_2SEQ, "b2b_second");
        take_result("b2b_second");
    endtask

    task automatic test_reset_drain;
        int seen = 0;
        start_job(ONES, ONES);
        repeat (5) tick;
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
        if (arr_clr !== 1'b1) begin errors++; $display("FAIL arst_arr_clr: got %b want 1", arr_clr); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        if (c_out !== 144'd0) begin errors++; $display("FAIL arst_c_out: got %h want 0", c_out); end
        tick;
        reset = 1'b1;
        repeat (15) begin
            tick;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL arst_abandon: got %0d valid cycles want 0", seen); end
        start_job(ID, SEQ);
        wait_result(1, C_SEQ, "after_rst");
        take_result("after_rst");
    endtask

    task automatic test_feed_ignore;
        start_job(SEQ, ID);
        in_valid = 1'b1;
        a_mat    = FULL;
        b_mat    = '0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ignore_in_ready: got %b want 0", in_ready); end
        tick;
        in_valid = 1'b0;
        a_mat    = ID;
        tick;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        a_mat    = '0;
        wait_result(4, C_SEQ, "ignore");
        take_result("ignore");
    endtask

`ifdef SA_CTRL_JOB_CNT_EN
    task automatic test_job_cnt;
        reset = 1'b0;
        #1;
        checks++;
        if (job_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", job_cnt); end
        tick;
        reset = 1'b1;
        tick;
        for (int n = 0; n < 3; n++) begin
            start_job(ONES, ONES);
            wait_result(1, C_3, "cnt_job");
            take_result("cnt_job");
        end
        checks++;
        if (job_cnt !== 16'd3) begin errors++; $display("FAIL cnt_three: got %0d want 3", job_cnt); end
        reset = 1'b0;
        #1;
        checks++;
        if (job_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", job_cnt); end
        tick;
        reset = 1'b1;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_identity;
        test_wrap;
        test_back_to_back;
        test_reset_drain;
        test_feed_ignore;
`ifdef SA_CTRL_JOB_CNT_EN
        test_job_cnt;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
